// File: rtl/wb_queue.sv
// In-order writeback queue: accepts up to NUM_SRC register writes per cycle and
// retires one per cycle to the register file, with forwarding over pending writes.
module wb_queue #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 4,
    parameter int NUM_RD  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [NUM_SRC-1:0]        src_we,
    input  logic [NUM_SRC*ADDR_W-1:0] src_waddr,
    input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
    input  logic                      wb_hold,
    input  logic [NUM_RD*ADDR_W-1:0]  fwd_raddr,
    output logic [NUM_RD-1:0]         fwd_hit,
    output logic [NUM_RD*DATA_W-1:0]  fwd_data,
    output logic                      we_out,
    output logic [ADDR_W-1:0]         waddr_out,
    output logic [DATA_W-1:0]         wdata_out,
    output logic                      stall_req,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NUM_SRC_C = CNT_W'(NUM_SRC);

    logic [ADDR_W-1:0] q_addr_reg [DEPTH];
    logic [DATA_W-1:0] q_data_reg [DEPTH];
    logic [DEPTH-1:0]  q_valid_reg;
    logic [PTR_W-1:0]  head_reg, tail_reg, head_next, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [ADDR_W-1:0] s_addr [NUM_SRC];
    logic [DATA_W-1:0] s_data [NUM_SRC];
    logic [PTR_W-1:0]  src_slot [NUM_SRC];
    logic [NUM_SRC-1:0] src_acc;
    logic [CNT_W-1:0]  acc_cnt;
    logic              pop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign s_addr[gi] = src_waddr[gi*ADDR_W +: ADDR_W];
            assign s_data[gi] = src_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Depends only on occupancy so producers can never form a loop through it.
    assign stall_req = (DEPTH_C - count_reg) < NUM_SRC_C;

    // Accepted sources are packed into consecutive tail slots, source 0 oldest.
    always_comb begin
        acc_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_acc[i]  = rdy && !stall_req && src_we[i] && (s_addr[i] != '0);
            src_slot[i] = tail_reg + acc_cnt[PTR_W-1:0];
            if (src_acc[i]) acc_cnt = acc_cnt + CNT_W'(1);
        end
    end

    assign pop        = rdy && !wb_hold && (count_reg != '0);
    assign count_next = count_reg + acc_cnt - CNT_W'(pop);
    assign head_next  = head_reg + PTR_W'(pop);
    assign tail_next  = tail_reg + acc_cnt[PTR_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid_reg <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
        end else if (rdy) begin
            if (pop) q_valid_reg[head_reg] <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_acc[i]) q_valid_reg[src_slot[i]] <= 1'b1;
            end
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            we_reg    <= pop;
            if (pop) begin
                waddr_reg <= q_addr_reg[head_reg];
                wdata_reg <= q_data_reg[head_reg];
            end
        end
    end

    // Payload storage needs no reset; the valid bits and count gate its use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_acc[i]) begin
                q_addr_reg[src_slot[i]] <= s_addr[i];
                q_data_reg[src_slot[i]] <= s_data[i];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_fwd
            logic [ADDR_W-1:0] raddr;
            logic              hit;
            logic [DATA_W-1:0] data;
            assign raddr = fwd_raddr[gi*ADDR_W +: ADDR_W];

            // Output register has lowest priority; queue scanned oldest to youngest
            // so the youngest matching entry overrides.
            always_comb begin
                logic [PTR_W-1:0] slot;
                slot = '0;
                hit  = 1'b0;
                data = '0;
                if (we_reg && (waddr_reg == raddr)) begin
                    hit  = 1'b1;
                    data = wdata_reg;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    slot = head_reg + PTR_W'(k);
                    if (q_valid_reg[slot] && (q_addr_reg[slot] == raddr)) begin
                        hit  = 1'b1;
                        data = q_data_reg[slot];
                    end
                end
                if (raddr == '0) begin
                    hit  = 1'b0;
                    data = '0;
                end
            end

            assign fwd_hit[gi]                  = hit;
            assign fwd_data[gi*DATA_W +: DATA_W] = data;
        end
    endgenerate

    assign we_out    = we_reg;
    assign waddr_out = waddr_reg;
    assign wdata_out = wdata_reg;
    assign count     = count_reg;
endmodule
